program_loader: RTL
===================

Name: program_loader

Overview:
- Write-side counterpart of the instruction memory read path.
- Accepts a byte stream from a host link, assembles little-endian 32-bit instruction words, and issues single-cycle write strobes into instruction memory at consecutive word addresses.
- Holds the core (program counter/fetch) frozen while a load is in progress.
- Releases the core when the requested word count has been written, or when the stream stalls.

Parameters:
- ADDR_W, 10, instruction memory word-address width; matches the program counter width.
- TIMEOUT, 1000, maximum idle cycles allowed between bytes during a load before it is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle request to begin a load. Sampled only in IDLE, DONE or ERROR.
- base_addr  input  ADDR_W  first word address. Latched on accepted load_start.
- word_count  input  ADDR_W+1  number of words to write. Latched on accepted load_start.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  32  write data.
- core_hold  output  1  freeze pc/fetch while high.
- load_done  output  1  level; a load completed successfully.
- load_error  output  1  level; the last load aborted on timeout.
- checksum  output  8  mod-256 sum of all bytes accepted in the current/last load.

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values (also applied on rst asserted mid-load): state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=0, load_done=0, load_error=0, checksum=0.
  - Partial memory contents written before a mid-load reset are left as-is.
- FSM states: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + load_start=1:
  - Latch base_addr into the address register and word_count into the remaining counter.
  - Clear checksum, byte index, timeout counter, load_done and load_error.
  - Set core_hold=1.
  - Go to RECV, or straight to DONE if word_count=0 (core_hold then drops the next cycle).
- load_start while in RECV or WRITE is ignored.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - The byte at index k (0..3) goes to word bits [8k+7:8k]; the first byte is the LSB.
  - checksum += byte, 8-bit wrap.
  - Each accepted byte clears the timeout counter; otherwise the counter increments.
  - When the counter reaches TIMEOUT, go to ERROR.
  - On acceptance of the 4th byte, go to WRITE.
- WRITE, exactly one cycle:
  - mem_we=1, mem_addr = current address, mem_wdata = assembled word; byte_ready=0.
  - Next cycle: address increments modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0), remaining decrements, byte index resets.
  - If remaining becomes 0 go to DONE, else go to RECV.
- mem_we is never high outside WRITE. Latency from 4th byte accepted to mem_we is 1 cycle.
- DONE: core_hold=0, load_done=1, byte_ready=0.
- ERROR: core_hold=0, load_error=1, byte_ready=0. Bytes already written stay in memory.
- byte_valid while byte_ready=0 is dropped; the sender must hold the byte until accepted.
- Simultaneous timeout expiry and byte acceptance in the same cycle: the byte wins and the counter clears.
- The maximum count 2^ADDR_W fills all of memory and ends with the address back at base_addr.

Decomposition:
- Shared package: FSM state encoding constants, BYTES_PER_WORD=4, and the default address width constant shared with the program counter.
- Natural sub-module: byte_packer, which holds the byte index, shift/insert into the 32-bit word, and word_full flag. The FSM and counters stay in program_loader.

Test Plan:
- Single-word load: load_start with base 0, count 1, then bytes 13,00,50,00 -> one mem_we pulse at addr 0 with wdata 0x00500013; load_done=1; core_hold low afterwards; checksum 0x63.
- Three-word load with byte_valid gaps (random stalls under TIMEOUT) -> mem_we at addrs 5,6,7 with the correct words, no extra strobes; core_hold high from the cycle after load_start until DONE.
- Address wrap: base 1022, count 3 (ADDR_W=10) -> writes land at 1022, 1023, 0.
- Timeout: count 2, send 6 bytes, then idle for TIMEOUT cycles -> exactly one write; load_error=1, load_done=0, core_hold=0.
- Count 0 -> no mem_we, load_done=1 one cycle after start. load_start during RECV -> ignored, stream continues unchanged.
- Reset mid-load: assert rst after 2 bytes of word 1 -> next cycle all outputs at reset values. A following clean load works normally and checksum reflects only the new load.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, word geometry and
// the default instruction address width shared with the program counter.
package program_loader_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from accepted bytes; flags the byte
// that completes the word so the loader can schedule the memory write.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [BYTE_IDX_W-1:0] r_idx;
  logic [31:0]           r_word;

  // Only the index restarts between words; every byte lane is rewritten
  // before the next write, so stale word contents never reach memory.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (i_accept) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx                        <= r_idx + 1'b1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_accept && (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Loads a host byte stream into instruction memory as 32-bit words while
// holding the core; ends on word count reached or on stream timeout.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_word_count,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_hold,
  output logic              o_load_done,
  output logic              o_load_error,
  output logic [7:0]        o_checksum
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic [TIMER_W-1:0]  r_timer;
  logic [7:0]          r_checksum;
  logic                r_hold;

  logic                w_start_ok;
  logic                w_accept;
  logic                w_timeout;
  logic                w_word_full;
  logic                w_pack_clear;
  logic [31:0]         w_word;

  assign w_start_ok   = i_load_start &&
                        (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
  assign w_accept     = i_byte_valid && (r_state == ST_RECV);
  // An accepted byte always beats an expiring timer in the same cycle.
  assign w_timeout    = !w_accept && (r_timer >= TIMER_W'(TIMEOUT - 1));
  assign w_pack_clear = w_start_ok || (r_state == ST_WRITE);

  program_loader_byte_packer u_packer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (w_pack_clear),
    .i_accept    (w_accept),
    .i_byte      (i_byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_start_ok) w_next = (i_word_count == '0) ? ST_DONE : ST_RECV;
      end
      ST_RECV: begin
        if (w_word_full)    w_next = ST_WRITE;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_WRITE: begin
        w_next = (r_remaining == (ADDR_W+1)'(1)) ? ST_DONE : ST_RECV;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Hold is registered so a zero-length load still freezes the core for the
  // single cycle it spends reaching DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_timer     <= '0;
      r_checksum  <= '0;
      r_hold      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hold  <= w_start_ok || (w_next == ST_RECV) || (w_next == ST_WRITE);
      if (w_start_ok) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_word_count;
        r_timer     <= '0;
        r_checksum  <= '0;
      end else if (r_state == ST_RECV) begin
        if (w_accept) begin
          r_checksum <= r_checksum + i_byte_in;
          r_timer    <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end else if (r_state == ST_WRITE) begin
        r_addr      <= r_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
        r_timer     <= '0;
      end
    end
  end

  assign o_byte_ready = (r_state == ST_RECV);
  assign o_mem_we     = (r_state == ST_WRITE);
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = w_word;
  assign o_core_hold  = r_hold;
  assign o_load_done  = (r_state == ST_DONE);
  assign o_load_error = (r_state == ST_ERROR);
  assign o_checksum   = r_checksum;

endmodule
